sprite_line_scheduler: RTL and testbench

Per-scanline sprite scheduler for one quadrant's VGA output path. Latches a frame-coherent snapshot of the alien object array at frame start. On each line-start request it scans all objects and selects up to SLOTS objects that cover the requested line, in index-priority order. It publishes a registered slot table that the object layer renderer consumes during the following scanline.

---
 rtl/sprite_line_scheduler_pkg.sv | 31 +++
 rtl/sprite_line_scheduler_if.sv | 31 +++
 rtl/sprite_hit_test.sv | 27 ++
 rtl/sprite_line_scheduler.sv | 151 +++++++++++++++
 tb/tb_sprite_line_scheduler.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/sprite_line_scheduler_pkg.sv
// Shared types for the per-scanline sprite scheduler: object record, slot entry, FSM states.
package sprite_line_scheduler_pkg;

  localparam int unsigned OBJ_LIMIT = 8;
  localparam int unsigned IDX_W     = $clog2(OBJ_LIMIT);
  localparam int unsigned ALIEN_W   = 35;
  localparam int unsigned COORD_W   = 10;

  // Packed MSB-first, so active lands at bit 0 of each object word.
  typedef struct packed {
    logic [7:0]         color;
    logic [3:0]         kind;
    logic [COORD_W-1:0] y_pos;
    logic [COORD_W-1:0] x_pos;
    logic [1:0]         quadrant;
    logic               active;
  } alien_data_t;

  typedef enum logic [1:0] {
    SCHED_IDLE,
    SCHED_SCAN,
    SCHED_COMMIT
  } sched_state_t;

  typedef struct packed {
    logic [IDX_W-1:0]   idx;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] row;
  } slot_entry_t;

endpackage

// File: rtl/sprite_line_scheduler_if.sv
// Bundle between the frame/line sequencer (master) and the sprite scheduler (slave).
interface sprite_line_scheduler_if import sprite_line_scheduler_pkg::*; #(
  parameter int unsigned SLOTS    = 4,
  parameter int unsigned SPRITE_H = 32
);
  localparam int unsigned ROW_W = $clog2(SPRITE_H);

  logic [OBJ_LIMIT*ALIEN_W-1:0] obj_data;
  logic                         frame_start;
  logic                         line_start;
  logic [COORD_W-1:0]           line;
  logic                         busy;
  logic                         done;
  logic [SLOTS-1:0]             slot_valid;
  logic [SLOTS*IDX_W-1:0]       slot_idx;
  logic [SLOTS*COORD_W-1:0]     slot_x;
  logic [SLOTS*ROW_W-1:0]       slot_row;
  logic                         overflow;
  logic [7:0]                   drop_count;

  modport master (
    output obj_data, frame_start, line_start, line,
    input  busy, done, slot_valid, slot_idx, slot_x, slot_row, overflow, drop_count
  );

  modport slave (
    input  obj_data, frame_start, line_start, line,
    output busy, done, slot_valid, slot_idx, slot_x, slot_row, overflow, drop_count
  );

endinterface

// File: rtl/sprite_hit_test.sv
// Combinational test of one object against one scanline; row is the line offset into the sprite.
module sprite_hit_test import sprite_line_scheduler_pkg::*; #(
  parameter int unsigned QUADRANT = 0,
  parameter int unsigned SPRITE_H = 32,
  localparam int unsigned ROW_W   = $clog2(SPRITE_H)
) (
  input  alien_data_t        obj,
  input  logic [COORD_W-1:0] line,
  output logic               hit,
  output logic [ROW_W-1:0]   row
);
  localparam int unsigned DIFF_W = COORD_W + 1;

  logic [DIFF_W-1:0] diff;
  logic              unused_fields;

  // One extra bit so a line above the sprite can never alias into range.
  assign diff = {1'b0, line} - {1'b0, obj.y_pos};
  assign hit  = obj.active
             && (obj.quadrant == 2'(QUADRANT))
             && (line >= obj.y_pos)
             && (diff < DIFF_W'(SPRITE_H));
  assign row  = diff[ROW_W-1:0];

  assign unused_fields = ^{obj.color, obj.kind, obj.x_pos};

endmodule

// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite scheduler: snapshots objects per frame, scans one per clock, commits a slot table.
// Optional SCHED_DROP_COUNT_EN adds a saturating per-frame drop counter; otherwise drop_count is 0.
module sprite_line_scheduler import sprite_line_scheduler_pkg::*; #(
  parameter int unsigned QUADRANT = 0,
  parameter int unsigned SLOTS    = 4,
  parameter int unsigned SPRITE_H = 32
) (
  input logic                     clk,
  input logic                     rst,
  sprite_line_scheduler_if.slave  bus
);
  localparam int unsigned ROW_W  = $clog2(SPRITE_H);
  localparam int unsigned SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  sched_state_t           state;
  alien_data_t            snap [OBJ_LIMIT];
  slot_entry_t            back [SLOTS];
  logic [SLOTS-1:0]       back_valid;
  logic [COORD_W-1:0]     line_q;
  logic [IDX_W-1:0]       scan_idx;

  logic                   busy_q, done_q, overflow_q;
  logic [SLOTS-1:0]       slot_valid_q;
  logic [SLOTS*IDX_W-1:0] slot_idx_q;
  logic [SLOTS*COORD_W-1:0] slot_x_q;
  logic [SLOTS*ROW_W-1:0] slot_row_q;

  logic                   hit;
  logic [ROW_W-1:0]       hit_row;
  logic                   free_ok;
  logic [SLOT_W-1:0]      free_sel;
  logic                   drop_event;
  logic                   unused_row_hi;

  sprite_hit_test #(.QUADRANT(QUADRANT), .SPRITE_H(SPRITE_H)) u_hit (
    .obj  (snap[scan_idx]),
    .line (line_q),
    .hit  (hit),
    .row  (hit_row)
  );

  // Lowest-numbered free back slot keeps slot order equal to object order.
  always_comb begin
    free_ok  = 1'b0;
    free_sel = '0;
    for (int s = int'(SLOTS) - 1; s >= 0; s--) begin
      if (!back_valid[s]) begin
        free_ok  = 1'b1;
        free_sel = SLOT_W'(s);
      end
    end
  end

  assign drop_event = (state == SCHED_SCAN) && !bus.line_start && hit && !free_ok;

  always_comb begin
    unused_row_hi = 1'b0;
    for (int s = 0; s < int'(SLOTS); s++) begin
      unused_row_hi = unused_row_hi ^ (^back[s].row[COORD_W-1:ROW_W]);
    end
  end

  // Frame-coherent snapshot; a scan in flight sees new data for objects not yet visited.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int o = 0; o < int'(OBJ_LIMIT); o++) snap[o] <= '0;
    end else if (bus.frame_start) begin
      for (int o = 0; o < int'(OBJ_LIMIT); o++)
        snap[o] <= alien_data_t'(bus.obj_data[o*ALIEN_W +: ALIEN_W]);
    end
  end

  // Scan FSM; a new line_start always wins and restarts from object 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= SCHED_IDLE;
      line_q       <= '0;
      scan_idx     <= '0;
      back_valid   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
      slot_valid_q <= '0;
      slot_idx_q   <= '0;
      slot_x_q     <= '0;
      slot_row_q   <= '0;
      for (int s = 0; s < int'(SLOTS); s++) back[s] <= '0;
    end else begin
      done_q <= 1'b0;
      if (bus.frame_start)     overflow_q <= 1'b0;
      else if (drop_event)     overflow_q <= 1'b1;

      if (bus.line_start) begin
        state      <= SCHED_SCAN;
        line_q     <= bus.line;
        scan_idx   <= '0;
        back_valid <= '0;
        busy_q     <= 1'b1;
        for (int s = 0; s < int'(SLOTS); s++) back[s] <= '0;
      end else begin
        case (state)
          SCHED_SCAN: begin
            if (hit && free_ok) begin
              back[free_sel].idx   <= scan_idx;
              back[free_sel].x     <= snap[scan_idx].x_pos;
              back[free_sel].row   <= COORD_W'(hit_row);
              back_valid[free_sel] <= 1'b1;
            end
            if (scan_idx == IDX_W'(OBJ_LIMIT - 1)) state <= SCHED_COMMIT;
            else                                   scan_idx <= scan_idx + IDX_W'(1);
          end
          SCHED_COMMIT: begin
            slot_valid_q <= back_valid;
            for (int s = 0; s < int'(SLOTS); s++) begin
              slot_idx_q[s*IDX_W +: IDX_W]     <= back[s].idx;
              slot_x_q[s*COORD_W +: COORD_W]   <= back[s].x;
              slot_row_q[s*ROW_W +: ROW_W]     <= back[s].row[ROW_W-1:0];
            end
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= SCHED_IDLE;
          end
          default: state <= SCHED_IDLE;
        endcase
      end
    end
  end

`ifdef SCHED_DROP_COUNT_EN
  logic [7:0] drop_q;

  always_ff @(posedge clk) begin
    if (!rst)                               drop_q <= '0;
    else if (bus.frame_start)               drop_q <= '0;
    else if (drop_event && drop_q != 8'hff) drop_q <= drop_q + 8'd1;
  end

  assign bus.drop_count = drop_q;
`else
  assign bus.drop_count = '0;
`endif

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.overflow   = overflow_q;
  assign bus.slot_valid = slot_valid_q;
  assign bus.slot_idx   = slot_idx_q;
  assign bus.slot_x     = slot_x_q;
  assign bus.slot_row   = slot_row_q;

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Directed bench for sprite_line_scheduler (OBJ_LIMIT=8, SLOTS=4, SPRITE_H=32, QUADRANT=1).
module tb_sprite_line_scheduler;
  import sprite_line_scheduler_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   lat;
  int   dones;
  alien_data_t objs [OBJ_LIMIT];

  sprite_line_scheduler_if #(.SLOTS(4), .SPRITE_H(32)) bus ();

  sprite_line_scheduler #(.QUADRANT(1), .SLOTS(4), .SPRITE_H(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_table(input string tag, input logic [3:0] v, input logic [11:0] idx,
                             input logic [39:0] x, input logic [19:0] row);
    check({tag, "_valid"}, 64'(bus.slot_valid), 64'(v));
    check({tag, "_idx"},   64'(bus.slot_idx),   64'(idx));
    check({tag, "_x"},     64'(bus.slot_x),     64'(x));
    check({tag, "_row"},   64'(bus.slot_row),   64'(row));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_objs();
    for (int o = 0; o < int'(OBJ_LIMIT); o++) objs[o] = '0;
  endtask

  task automatic set_obj(input int k, input int q, input int x, input int y);
    objs[k]          = '0;
    objs[k].active   = 1'b1;
    objs[k].quadrant = 2'(q);
    objs[k].x_pos    = 10'(x);
    objs[k].y_pos    = 10'(y);
  endtask

  task automatic drive_objs();
    for (int o = 0; o < int'(OBJ_LIMIT); o++) bus.obj_data[o*ALIEN_W +: ALIEN_W] = objs[o];
  endtask

  task automatic frame_pulse();
    drive_objs();
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
  endtask

  // Waits (bounded) for done after the last line_start edge; lat = edges to done, 0 on timeout.
  task automatic wait_done(output int l);
    l = 0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (bus.done) begin
        l = c;
        break;
      end
    end
  endtask

  task automatic run_line(input int ln, input string tag);
    int l;
    bus.line       = 10'(ln);
    bus.line_start = 1'b1;
    tick();
    bus.line_start = 1'b0;
    check({tag, "_busy_rise"}, 64'(bus.busy), 64'd1);
    wait_done(l);
    check({tag, "_latency"}, 64'(l), 64'd9);
    check({tag, "_busy_fall"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    bus.obj_data    = '0;
    bus.frame_start = 1'b0;
    bus.line_start  = 1'b0;
    bus.line        = '0;
    clear_objs();

    // Reset and idle state
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_overflow", 64'(bus.overflow), 64'd0);
    check("rst_drop", 64'(bus.drop_count), 64'd0);
    check_table("rst", 4'b0000, 12'd0, 40'd0, 20'd0);

    // Empty snapshot: done after 9 clocks, nothing scheduled
    run_line(100, "empty");
    check_table("empty", 4'b0000, 12'd0, 40'd0, 20'd0);
    tick();
    check("done_one_cycle", 64'(bus.done), 64'd0);

    // Two hits in index order
    set_obj(2, 1, 40, 90);
    set_obj(5, 1, 300, 100);
    frame_pulse();
    run_line(110, "two");
    check_table("two", 4'b0011, {3'd0, 3'd0, 3'd5, 3'd2},
                {10'd0, 10'd0, 10'd300, 10'd40}, {5'd0, 5'd0, 5'd10, 5'd20});
    check("two_overflow", 64'(bus.overflow), 64'd0);

    // Wrong quadrant never hits; row 32 is out of range, row 31 is in; line above sprite misses
    clear_objs();
    set_obj(3, 2, 11, 100);
    set_obj(4, 1, 22, 100);
    frame_pulse();
    run_line(132, "row32");
    check_table("row32", 4'b0000, 12'd0, 40'd0, 20'd0);
    run_line(131, "row31");
    check_table("row31", 4'b0001, {3'd0, 3'd0, 3'd0, 3'd4},
                {10'd0, 10'd0, 10'd0, 10'd22}, {5'd0, 5'd0, 5'd0, 5'd31});
    run_line(99, "above");
    check_table("above", 4'b0000, 12'd0, 40'd0, 20'd0);

    // Eight hits: first four kept, four dropped
    for (int k = 0; k < 8; k++) set_obj(k, 1, 10 * k, 40);
    frame_pulse();
    run_line(50, "full");
    check_table("full", 4'b1111, {3'd3, 3'd2, 3'd1, 3'd0},
                {10'd30, 10'd20, 10'd10, 10'd0}, {5'd10, 5'd10, 5'd10, 5'd10});
    check("full_overflow", 64'(bus.overflow), 64'd1);
`ifdef SCHED_DROP_COUNT_EN
    check("full_drop", 64'(bus.drop_count), 64'd4);
`else
    check("full_drop", 64'(bus.drop_count), 64'd0);
`endif
    frame_pulse();
    check("frame_clr_overflow", 64'(bus.overflow), 64'd0);
    check("frame_clr_drop", 64'(bus.drop_count), 64'd0);
    check("frame_keeps_table", 64'(bus.slot_valid), 64'hf);

    // Abort: second line_start three edges after the first
    clear_objs();
    set_obj(2, 1, 40, 90);
    set_obj(5, 1, 300, 100);
    frame_pulse();
    bus.line       = 10'd110;
    bus.line_start = 1'b1;
    tick();
    bus.line_start = 1'b0;
    dones = 0;
    for (int c = 0; c < 2; c++) begin
      tick();
      if (bus.done) dones++;
    end
    bus.line       = 10'd95;
    bus.line_start = 1'b1;
    tick();
    bus.line_start = 1'b0;
    if (bus.done) dones++;
    check("abort_no_early_done", 64'(dones), 64'd0);
    check("abort_busy", 64'(bus.busy), 64'd1);
    check("abort_old_table", 64'(bus.slot_valid), 64'hf);
    wait_done(lat);
    check("abort_latency", 64'(lat), 64'd9);
    check_table("abort", 4'b0001, {3'd0, 3'd0, 3'd0, 3'd2},
                {10'd0, 10'd0, 10'd0, 10'd40}, {5'd0, 5'd0, 5'd0, 5'd5});

    // Reset mid-scan: idle, table zeroed, no done afterwards
    bus.line       = 10'd110;
    bus.line_start = 1'b1;
    tick();
    bus.line_start = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_done", 64'(bus.done), 64'd0);
    check_table("midrst", 4'b0000, 12'd0, 40'd0, 20'd0);
    rst = 1'b1;
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (bus.done) dones++;
    end
    check("midrst_no_done", 64'(dones), 64'd0);

    // frame_start and line_start together: scan sees the fresh snapshot
    drive_objs();
    bus.frame_start = 1'b1;
    bus.line        = 10'd110;
    bus.line_start  = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    bus.line_start  = 1'b0;
    wait_done(lat);
    check("same_edge_latency", 64'(lat), 64'd9);
    check_table("same_edge", 4'b0011, {3'd0, 3'd0, 3'd5, 3'd2},
                {10'd0, 10'd0, 10'd300, 10'd40}, {5'd0, 5'd0, 5'd10, 5'd20});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
